// File: rtl/wb_writer_pkg.sv
// Shared types and helpers for the register-bank writeback controller.
package wb_writer_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;

    // One pending register write: destination and value.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] wa;
        logic [DATA_W-1:0]     data;
    } wb_req_t;

    // Decode a register address into a one-bit-per-register mask.
    function automatic logic [NUM_REGS-1:0] onehot32(input logic [REG_ADDR_W-1:0] addr);
        return NUM_REGS'(1) << addr;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Result FIFO for the multi-cycle producer. Besides the usual head/count
// view it exposes every slot's destination and valid bit so the
// arbiter can detect WAW conflicts and build the pending-write mask.
module wb_fifo
    import wb_writer_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int WA_W  = REG_ADDR_W,
    parameter  int DW    = DATA_W,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WA_W-1:0]            push_wa_i,
    input  logic [DW-1:0]              push_data_i,
    input  logic                       pop_i,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [CNT_W-1:0]           cnt_o,
    output logic [WA_W-1:0]            head_wa_o,
    output logic [DW-1:0]              head_data_o,
    output logic [DEPTH-1:0][WA_W-1:0] entry_wa_o,
    output logic [DEPTH-1:0]           entry_vld_o
);

    logic [DEPTH-1:0][WA_W-1:0] wa_mem_q;
    logic [DW-1:0]              data_mem_q [DEPTH];
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [DEPTH-1:0]           vld_q, vld_d;
    logic                       push_ok, pop_ok;

    assign full_o      = (cnt_q == CNT_W'(DEPTH));
    assign empty_o     = (cnt_q == '0);
    assign cnt_o       = cnt_q;
    assign head_wa_o   = wa_mem_q[rd_ptr_q];
    assign head_data_o = data_mem_q[rd_ptr_q];
    assign entry_wa_o  = wa_mem_q;
    assign entry_vld_o = vld_q;

    // Guard against pushing into a full FIFO or popping an empty one.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Next-state for pointers, occupancy and per-slot valid bits.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        vld_d    = vld_q;
        if (push_ok) begin
            wr_ptr_d        = wr_ptr_q + 1'b1;
            vld_d[wr_ptr_q] = 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d        = rd_ptr_q + 1'b1;
            vld_d[rd_ptr_q] = 1'b0;
        end
        cnt_d = cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    // Control state: cleared by reset so a reset discards all queued entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            vld_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            vld_q    <= vld_d;
        end
    end

    // Slot storage: written at the tail on push.
    // NOTE: storage is not reset; the valid bits decide whether a slot means anything.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            wa_mem_q[wr_ptr_q]   <= push_wa_i;
            data_mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/wb_writer.sv
// Writeback controller: merges the single-cycle ALU result path with the
// buffered load/mul path onto the register bank's single write port,
// keeping WAW order per destination and publishing a pending-write mask.
module wb_writer
    import wb_writer_pkg::*;
#(
    parameter  int DEPTH    = 4,
    parameter  bit ZERO_REG = 1'b1,
    localparam int CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s0_valid,
    output logic                  s0_ready,
    input  logic [REG_ADDR_W-1:0] s0_wa,
    input  logic [DATA_W-1:0]     s0_data,
    input  logic                  s1_valid,
    output logic                  s1_ready,
    input  logic [REG_ADDR_W-1:0] s1_wa,
    input  logic [DATA_W-1:0]     s1_data,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_wa,
    output logic [DATA_W-1:0]     rf_dw,
    output logic [NUM_REGS-1:0]   pend_mask,
    output logic [CNT_W-1:0]      fifo_cnt
);

    logic                             fifo_full, fifo_empty;
    logic [REG_ADDR_W-1:0]            head_wa;
    logic [DATA_W-1:0]                head_data;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] entry_wa;
    logic [DEPTH-1:0]                 entry_vld;

    logic    conflict, grant_s0, grant_fifo, gnt_valid;
    wb_req_t gnt_req;

    logic                  rf_we_q, rf_we_d;
    logic [REG_ADDR_W-1:0] rf_wa_q, rf_wa_d;
    logic [DATA_W-1:0]     rf_dw_q, rf_dw_d;

    // A full FIFO refuses new items outright; there is no bypass path.
    assign s1_ready = !fifo_full;
    assign s0_ready = grant_s0;

    wb_fifo #(
        .DEPTH (DEPTH),
        .WA_W  (REG_ADDR_W),
        .DW    (DATA_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (s1_valid && s1_ready),
        .push_wa_i   (s1_wa),
        .push_data_i (s1_data),
        .pop_i       (grant_fifo),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .cnt_o       (fifo_cnt),
        .head_wa_o   (head_wa),
        .head_data_o (head_data),
        .entry_wa_o  (entry_wa),
        .entry_vld_o (entry_vld)
    );

    // The ALU result must wait while any older queued write targets the same register.
    always_comb begin
        conflict = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_vld[i] && (entry_wa[i] == s0_wa)) conflict = 1'b1;
        end
    end

    // Grant: a full FIFO drains first, then the ALU, then any queued result.
    always_comb begin
        grant_s0   = 1'b0;
        grant_fifo = 1'b0;
        if (fifo_full) begin
            grant_fifo = 1'b1;
        end else if (s0_valid && !conflict) begin
            grant_s0 = 1'b1;
        end else if (!fifo_empty) begin
            grant_fifo = 1'b1;
        end
        gnt_valid = grant_s0 || grant_fifo;
        gnt_req   = grant_s0 ? '{wa: s0_wa, data: s0_data} : '{wa: head_wa, data: head_data};
    end

    // Output register next-state; address/data hold when nothing is granted.
    always_comb begin
        rf_we_d = gnt_valid && !(ZERO_REG && (gnt_req.wa == '0));
        rf_wa_d = gnt_valid ? gnt_req.wa   : rf_wa_q;
        rf_dw_d = gnt_valid ? gnt_req.data : rf_dw_q;
    end

    // Registered write port into the bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_q <= 1'b0;
            rf_wa_q <= '0;
            rf_dw_q <= '0;
        end else begin
            rf_we_q <= rf_we_d;
            rf_wa_q <= rf_wa_d;
            rf_dw_q <= rf_dw_d;
        end
    end

    assign rf_we = rf_we_q;
    assign rf_wa = rf_wa_q;
    assign rf_dw = rf_dw_q;

    // Pending writes: every queued destination plus the one currently on the port.
    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_vld[i]) pend_mask = pend_mask | onehot32(entry_wa[i]);
        end
        if (rf_we_q) pend_mask = pend_mask | onehot32(rf_wa_q);
        if (ZERO_REG) pend_mask[0] = 1'b0;
    end

endmodule

// File: tb/tb_wb_writer.sv
// Directed bench for wb_writer: reset, ALU path, zero register, WAW order,
// full-FIFO priority, mid-stream reset, then a random soak against an
// in-order per-register golden model.
module tb_wb_writer;
    import wb_writer_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                  clk;
    logic                  rst_n;
    logic                  s0_valid, s0_ready;
    logic [REG_ADDR_W-1:0] s0_wa;
    logic [DATA_W-1:0]     s0_data;
    logic                  s1_valid, s1_ready;
    logic [REG_ADDR_W-1:0] s1_wa;
    logic [DATA_W-1:0]     s1_data;
    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_wa;
    logic [DATA_W-1:0]     rf_dw;
    logic [NUM_REGS-1:0]   pend_mask;
    logic [CNT_W-1:0]      fifo_cnt;

    int checks = 0;
    int errors = 0;

    // Bank model and write log, fed by the registered write port.
    logic [DATA_W-1:0] bank [NUM_REGS];
    wb_req_t           wq [$];
    int                wr_cnt = 0;

    wb_writer #(.DEPTH(DEPTH), .ZERO_REG(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s0_valid  (s0_valid),
        .s0_ready  (s0_ready),
        .s0_wa     (s0_wa),
        .s0_data   (s0_data),
        .s1_valid  (s1_valid),
        .s1_ready  (s1_ready),
        .s1_wa     (s1_wa),
        .s1_data   (s1_data),
        .rf_we     (rf_we),
        .rf_wa     (rf_wa),
        .rf_dw     (rf_dw),
        .pend_mask (pend_mask),
        .fifo_cnt  (fifo_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rf_we) begin
            bank[rf_wa] = rf_dw;
            wq.push_back('{wa: rf_wa, data: rf_dw});
            wr_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int r = 0; r < NUM_REGS; r++) bank[r] = '0;
        wq.delete();
        wr_cnt = 0;
    endtask

    logic [DATA_W-1:0] gold [NUM_REGS];
    int                exp_cnt;
    logic              acc0, acc1;
    wb_req_t           exp_seq [$];
    wb_req_t           got;

    initial begin
        rst_n = 1'b0; s0_valid = 1'b0; s0_wa = '0; s0_data = '0;
        s1_valid = 1'b0; s1_wa = '0; s1_data = '0;
        clear_model();
        #2;
        check("reset_rf_we", 64'(rf_we), 64'd0);
        check("reset_rf_wa", 64'(rf_wa), 64'd0);
        check("reset_rf_dw", 64'(rf_dw), 64'd0);
        check("reset_cnt", 64'(fifo_cnt), 64'd0);
        check("reset_pend", 64'(pend_mask), 64'd0);
        #20 rst_n = 1'b1;
        step();

        // ALU only: r5 <= 0x12345678
        s0_valid = 1'b1; s0_wa = 5'd5; s0_data = 32'h1234_5678;
        #1 check("alu_ready", 64'(s0_ready), 64'd1);
        step();
        s0_valid = 1'b0;
        #1;
        check("alu_we", 64'(rf_we), 64'd1);
        check("alu_wa", 64'(rf_wa), 64'd5);
        check("alu_dw", 64'(rf_dw), 64'h1234_5678);
        check("alu_pend", 64'(pend_mask), 64'h20);
        step();
        check("idle_we", 64'(rf_we), 64'd0);
        check("idle_wa_hold", 64'(rf_wa), 64'd5);
        check("idle_dw_hold", 64'(rf_dw), 64'h1234_5678);
        check("idle_pend", 64'(pend_mask), 64'd0);

        // Zero register: accepted, never written.
        s0_valid = 1'b1; s0_wa = 5'd0; s0_data = 32'hFFFF_FFFF;
        #1 check("zero_ready", 64'(s0_ready), 64'd1);
        step();
        s0_valid = 1'b0;
        #1;
        check("zero_we", 64'(rf_we), 64'd0);
        check("zero_pend", 64'(pend_mask), 64'd0);
        step();

        // WAW: queued r7=0xA must reach the bank before ALU r7=0xB.
        s1_valid = 1'b1; s1_wa = 5'd7; s1_data = 32'hA;
        #1 check("waw_s1_ready", 64'(s1_ready), 64'd1);
        step();
        s1_valid = 1'b0;
        s0_valid = 1'b1; s0_wa = 5'd7; s0_data = 32'hB;
        #1;
        check("waw_cnt", 64'(fifo_cnt), 64'd1);
        check("waw_s0_blocked", 64'(s0_ready), 64'd0);
        check("waw_pend_q", 64'(pend_mask), 64'h80);
        step();
        check("waw_first_we", 64'(rf_we), 64'd1);
        check("waw_first", {27'd0, rf_wa, rf_dw}, {27'd0, 5'd7, 32'hA});
        check("waw_s0_now", 64'(s0_ready), 64'd1);
        check("waw_cnt0", 64'(fifo_cnt), 64'd0);
        step();
        s0_valid = 1'b0;
        check("waw_second_we", 64'(rf_we), 64'd1);
        check("waw_second", {27'd0, rf_wa, rf_dw}, {27'd0, 5'd7, 32'hB});
        step();

        // Full-FIFO priority: s1 fills r10..r13 while s0 streams r1..r4.
        wq.delete();
        for (int i = 0; i < 4; i++) begin
            s0_valid = 1'b1; s0_wa = 5'(1 + i);  s0_data = 32'h200 + 32'(i);
            s1_valid = 1'b1; s1_wa = 5'(10 + i); s1_data = 32'h100 + 32'(i);
            #1;
            check("full_fill_s0", 64'(s0_ready), 64'd1);
            check("full_fill_s1", 64'(s1_ready), 64'd1);
            step();
        end
        s0_wa = 5'd5;  s0_data = 32'h205;
        s1_wa = 5'd14; s1_data = 32'h104;
        #1;
        check("full_cnt", 64'(fifo_cnt), 64'd4);
        check("full_s0_ready", 64'(s0_ready), 64'd0);
        check("full_s1_ready", 64'(s1_ready), 64'd0);
        check("full_pend", 64'(pend_mask), 64'h3C10);
        step();
        check("after_pop_cnt", 64'(fifo_cnt), 64'd3);
        check("after_pop_s0", 64'(s0_ready), 64'd1);
        check("after_pop_s1", 64'(s1_ready), 64'd1);
        step();
        s0_valid = 1'b0; s1_valid = 1'b0;
        for (int i = 0; i < 8; i++) step();
        exp_seq = '{'{5'd1, 32'h200}, '{5'd2, 32'h201}, '{5'd3, 32'h202}, '{5'd4, 32'h203},
                    '{5'd10, 32'h100}, '{5'd5, 32'h205}, '{5'd11, 32'h101}, '{5'd12, 32'h102},
                    '{5'd13, 32'h103}, '{5'd14, 32'h104}};
        check("full_nwrites", 64'(wq.size()), 64'(exp_seq.size()));
        for (int i = 0; i < exp_seq.size(); i++) begin
            got = (i < wq.size()) ? wq[i] : '0;
            check($sformatf("full_seq%0d", i), 64'(got), 64'(exp_seq[i]));
        end

        // Reset mid-stream with three queued entries.
        for (int i = 0; i < 3; i++) begin
            s0_valid = 1'b1; s0_wa = 5'(2 + i);  s0_data = 32'(i);
            s1_valid = 1'b1; s1_wa = 5'(20 + i); s1_data = 32'h300 + 32'(i);
            step();
        end
        s0_valid = 1'b0; s1_valid = 1'b0;
        #1 check("mid_cnt3", 64'(fifo_cnt), 64'd3);
        rst_n = 1'b0;
        #1;
        check("mid_rst_cnt", 64'(fifo_cnt), 64'd0);
        check("mid_rst_we", 64'(rf_we), 64'd0);
        check("mid_rst_pend", 64'(pend_mask), 64'd0);
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) step();
        check("mid_no_writes", 64'(wq.size()), 64'd0);

        // Random soak against an in-order golden model.
        clear_model();
        for (int r = 0; r < NUM_REGS; r++) gold[r] = '0;
        exp_cnt = 0;
        acc0 = 1'b1; acc1 = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (!s0_valid || acc0) begin
                s0_valid = 1'($urandom_range(0, 1));
                s0_wa    = 5'($urandom_range(0, 7));
                s0_data  = $urandom;
            end
            if (!s1_valid || acc1) begin
                s1_valid = 1'($urandom_range(0, 1));
                s1_wa    = 5'($urandom_range(0, 7));
                s1_data  = $urandom;
            end
            #1;
            acc0 = s0_valid && s0_ready;
            acc1 = s1_valid && s1_ready;
            if (acc0 && s0_wa != 5'd0) begin gold[s0_wa] = s0_data; exp_cnt++; end
            if (acc1 && s1_wa != 5'd0) begin gold[s1_wa] = s1_data; exp_cnt++; end
            step();
        end
        s0_valid = 1'b0; s1_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (fifo_cnt == '0 && !rf_we) break;
            step();
        end
        check("soak_drained", 64'(fifo_cnt), 64'd0);
        step();
        check("soak_nwrites", 64'(wr_cnt), 64'(exp_cnt));
        for (int r = 0; r < NUM_REGS; r++) begin
            check($sformatf("soak_r%0d", r), 64'(bank[r]), 64'(gold[r]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
